// File: rtl/k051962_layer_mixer.sv
// Three-stage layer mixer wrapped around the 256x4 priority PROM:
// S0 registers pixels and drives the PROM address, S1 samples PROM_Q, S2 drives the palette index.
module k051962_layer_mixer #(
  parameter int unsigned PROM_WAIT = 3,
  parameter int unsigned PIX_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE_PIX,
  input  logic [PIX_W-1:0] FIX_PIX,
  input  logic [PIX_W-1:0] VA_PIX,
  input  logic [PIX_W-1:0] VB_PIX,
  input  logic [PIX_W-1:0] OBJ_PIX,
  input  logic [2:0]       OBP,
  input  logic             BLANK_IN,
  output logic [7:0]       PROM_ADDR,
  output logic             PROM_EN1n,
  output logic             PROM_EN2n,
  input  logic [3:0]       PROM_Q,
  output logic [PIX_W+1:0] PAL_IDX,
  output logic             SHADOW,
  output logic             BLANK_OUT,
  output logic             TIMING_ERR
);

  localparam int unsigned CNT_W = (PROM_WAIT > 0) ? $clog2(PROM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(PROM_WAIT);

  logic             prom_en_n;
  logic [CNT_W-1:0] wait_cnt;

  logic             n_fix;
  logic             n_va;
  logic             n_vb;
  logic             n_obj;
  logic [7:0]       addr_next;

  logic [PIX_W-1:0] fix_s0;
  logic [PIX_W-1:0] va_s0;
  logic [PIX_W-1:0] vb_s0;
  logic [PIX_W-1:0] obj_s0;
  logic             blank_s0;

  logic [3:0]       q_s1;
  logic [PIX_W-1:0] fix_s1;
  logic [PIX_W-1:0] va_s1;
  logic [PIX_W-1:0] vb_s1;
  logic [PIX_W-1:0] obj_s1;
  logic             blank_s1;
  logic [PIX_W-1:0] sel_code;

  // A single register drives both enables so they can never disagree.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prom_en_n <= 1'b1;
    end else begin
      prom_en_n <= 1'b0;
    end
  end

  assign PROM_EN1n = prom_en_n;
  assign PROM_EN2n = prom_en_n;

  always_comb begin
    n_fix     = (FIX_PIX[3:0] == 4'h0);
    n_va      = (VA_PIX[3:0]  == 4'h0);
    n_vb      = (VB_PIX[3:0]  == 4'h0);
    n_obj     = (OBJ_PIX[3:0] == 4'h0);
    addr_next = {1'b0, OBP[0], OBP[1], OBP[2], n_fix, n_obj, n_vb, n_va};
  end

  // Address is captured with the S0 pixel so it reads 0 out of reset and only moves on CE_PIX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PROM_ADDR <= '0;
      fix_s0    <= '0;
      va_s0     <= '0;
      vb_s0     <= '0;
      obj_s0    <= '0;
      blank_s0  <= 1'b1;
    end else if (CE_PIX) begin
      PROM_ADDR <= addr_next;
      fix_s0    <= FIX_PIX;
      va_s0     <= VA_PIX;
      vb_s0     <= VB_PIX;
      obj_s0    <= OBJ_PIX;
      blank_s0  <= BLANK_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt   <= '0;
      TIMING_ERR <= 1'b0;
    end else if (CE_PIX) begin
      if (wait_cnt != '0) begin
        TIMING_ERR <= 1'b1;
      end
      wait_cnt <= WAIT_LOAD;
    end else if (wait_cnt != '0) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_s1     <= '0;
      fix_s1   <= '0;
      va_s1    <= '0;
      vb_s1    <= '0;
      obj_s1   <= '0;
      blank_s1 <= 1'b1;
    end else if (CE_PIX) begin
      q_s1     <= PROM_Q;
      fix_s1   <= fix_s0;
      va_s1    <= va_s0;
      vb_s1    <= vb_s0;
      obj_s1   <= obj_s0;
      blank_s1 <= blank_s0;
    end
  end

  always_comb begin
    sel_code = fix_s1;
    case (q_s1[1:0])
      2'd0:    sel_code = fix_s1;
      2'd1:    sel_code = va_s1;
      2'd2:    sel_code = vb_s1;
      default: sel_code = obj_s1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PAL_IDX   <= '0;
      SHADOW    <= 1'b0;
      BLANK_OUT <= 1'b1;
    end else if (CE_PIX) begin
      if (q_s1[3] || blank_s1) begin
        PAL_IDX <= '0;
        SHADOW  <= 1'b0;
      end else begin
        PAL_IDX <= {q_s1[1:0], sel_code};
        SHADOW  <= q_s1[2];
      end
      BLANK_OUT <= blank_s1;
    end
  end

endmodule

// File: tb/tb_k051962_layer_mixer.sv
// Self-checking bench: a queue-based pixel model plus a PROM array, checked every cycle.
module tb_k051962_layer_mixer;

  localparam int unsigned W = 3;

  typedef struct {
    logic [7:0] fix;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] obj;
    logic [2:0] obp;
    logic       blank;
    logic [3:0] q;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_pix = 1'b0;
  logic [7:0] fix_pix = '0;
  logic [7:0] va_pix = '0;
  logic [7:0] vb_pix = '0;
  logic [7:0] obj_pix = '0;
  logic [2:0] obp = '0;
  logic       blank_in = 1'b0;
  logic [7:0] prom_addr;
  logic       prom_en1n;
  logic       prom_en2n;
  logic [3:0] prom_q;
  logic [9:0] pal_idx;
  logic       shadow;
  logic       blank_out;
  logic       timing_err;

  logic [3:0] prom_mem [256];
  assign prom_q = prom_mem[prom_addr];

  k051962_layer_mixer #(
    .PROM_WAIT(W),
    .PIX_W(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .CE_PIX(ce_pix),
    .FIX_PIX(fix_pix),
    .VA_PIX(va_pix),
    .VB_PIX(vb_pix),
    .OBJ_PIX(obj_pix),
    .OBP(obp),
    .BLANK_IN(blank_in),
    .PROM_ADDR(prom_addr),
    .PROM_EN1n(prom_en1n),
    .PROM_EN2n(prom_en2n),
    .PROM_Q(prom_q),
    .PAL_IDX(pal_idx),
    .SHADOW(shadow),
    .BLANK_OUT(blank_out),
    .TIMING_ERR(timing_err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  logic [7:0] e_addr;
  logic       e_en_n;
  logic [9:0] e_pal;
  logic       e_sh;
  logic       e_blank;
  logic       e_err;
  int         since;
  pix_t       fl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pix_t mk(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] o, input logic [2:0] p, input logic bl);
    pix_t r;
    r.fix = f; r.va = a; r.vb = b; r.obj = o; r.obp = p; r.blank = bl; r.q = '0;
    return r;
  endfunction

  function automatic logic [7:0] rcode();
    logic [3:0] pen;
    pen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return {4'($urandom_range(0, 15)), pen};
  endfunction

  function automatic pix_t rpix();
    return mk(rcode(), rcode(), rcode(), rcode(), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0));
  endfunction

  function automatic logic [7:0] addr_of(input pix_t p);
    return {1'b0, p.obp[0], p.obp[1], p.obp[2],
            (p.fix[3:0] == 4'h0), (p.obj[3:0] == 4'h0), (p.vb[3:0] == 4'h0), (p.va[3:0] == 4'h0)};
  endfunction

  task automatic model_reset();
    pix_t bub;
    bub = mk(8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    fl.delete();
    fl.push_back(bub);
    fl.push_back(bub);
    e_addr = '0; e_en_n = 1'b1; e_pal = '0; e_sh = 1'b0; e_blank = 1'b1; e_err = 1'b0;
    since = W + 1;
  endtask

  // Oldest pixel leaves, the middle one picks up the PROM word for its address, the new one enters.
  task automatic model_step(input pix_t np);
    pix_t old;
    logic [7:0] code;
    old = fl.pop_front();
    case (old.q[1:0])
      2'd0:    code = old.fix;
      2'd1:    code = old.va;
      2'd2:    code = old.vb;
      default: code = old.obj;
    endcase
    if (old.q[3] || old.blank) begin
      e_pal = '0; e_sh = 1'b0;
    end else begin
      e_pal = {old.q[1:0], code}; e_sh = old.q[2];
    end
    e_blank = old.blank;
    fl[0].q = prom_mem[e_addr];
    fl.push_back(np);
    e_addr = addr_of(np);
  endtask

  task automatic tick(input bit ce, input bit r);
    pix_t cur;
    ce_pix = ce;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      e_en_n = 1'b0;
      since++;
      if (ce) begin
        if (since <= W) e_err = 1'b1;
        since = 0;
        cur = mk(fix_pix, va_pix, vb_pix, obj_pix, obp, blank_in);
        model_step(cur);
      end
    end
    ce_pix = 1'b0;
  endtask

  task automatic send_ce(input pix_t p);
    fix_pix = p.fix; va_pix = p.va; vb_pix = p.vb; obj_pix = p.obj;
    obp = p.obp; blank_in = p.blank;
    tick(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    pix_t j;
    for (int i = 0; i < n; i++) begin
      j = rpix();
      fix_pix = j.fix; va_pix = j.va; vb_pix = j.vb; obj_pix = j.obj;
      obp = j.obp; blank_in = j.blank;
      tick(1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en1n", {31'd0, prom_en1n}, {31'd0, e_en_n});
      chk("en2n", {31'd0, prom_en2n}, {31'd0, e_en_n});
      chk("prom_addr", {24'd0, prom_addr}, {24'd0, e_addr});
      chk("pal_idx", {22'd0, pal_idx}, {22'd0, e_pal});
      chk("shadow", {31'd0, shadow}, {31'd0, e_sh});
      chk("blank_out", {31'd0, blank_out}, {31'd0, e_blank});
      chk("timing_err", {31'd0, timing_err}, {31'd0, e_err});
    end
  end

  pix_t pa, pb, pc, pd;

  initial begin
    model_reset();
    foreach (prom_mem[i]) prom_mem[i] = 4'($urandom_range(0, 15));
    pa = mk(8'h00, 8'h20, 8'h47, 8'h35, 3'b101, 1'b0);
    pb = mk(8'h00, 8'h00, 8'h47, 8'h00, 3'b000, 1'b0);
    pc = mk(8'h12, 8'h34, 8'h56, 8'h78, 3'b111, 1'b0);
    pd = mk(8'h9A, 8'h11, 8'h00, 8'h00, 3'b010, 1'b1);
    prom_mem[8'h59] = 4'b0111;
    prom_mem[8'h0D] = 4'b0110;
    prom_mem[8'h70] = 4'b1011;
    prom_mem[8'h26] = 4'b0001;

    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      chk_on = 1'b1;
      chk("rst_en1n", {31'd0, prom_en1n}, 32'd1);
      chk("rst_en2n", {31'd0, prom_en2n}, 32'd1);
      chk("rst_blank", {31'd0, blank_out}, 32'd1);
      chk("rst_pal", {22'd0, pal_idx}, 32'd0);
    end
    tick(1'b0, 1'b0);
    chk("rel_en1n", {31'd0, prom_en1n}, 32'd0);
    chk("rel_en2n", {31'd0, prom_en2n}, 32'd0);
    idle(3);

    send_ce(pa);
    chk("addr_59", {24'd0, prom_addr}, 32'h59);
    idle(3);
    send_ce(pb);
    chk("addr_0d", {24'd0, prom_addr}, 32'h0D);
    idle(3);
    send_ce(pc);
    chk("obj_pal", {22'd0, pal_idx}, 32'h335);
    chk("obj_sh", {31'd0, shadow}, 32'd1);
    idle(3);
    send_ce(pd);
    chk("vb_pal", {22'd0, pal_idx}, 32'h247);
    chk("vb_sh", {31'd0, shadow}, 32'd1);
    idle(3);
    send_ce(rpix());
    chk("bd_pal", {22'd0, pal_idx}, 32'd0);
    chk("bd_sh", {31'd0, shadow}, 32'd0);
    chk("bd_blank", {31'd0, blank_out}, 32'd0);
    idle(3);
    send_ce(rpix());
    chk("bl_pal", {22'd0, pal_idx}, 32'd0);
    chk("bl_sh", {31'd0, shadow}, 32'd0);
    chk("bl_blank", {31'd0, blank_out}, 32'd1);

    idle(20);
    send_ce(rpix());
    idle(3);
    send_ce(rpix());
    idle(3);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    send_ce(pa);
    chk("post1_pal", {22'd0, pal_idx}, 32'd0);
    chk("post1_blank", {31'd0, blank_out}, 32'd1);
    idle(3);
    send_ce(rpix());
    chk("post2_pal", {22'd0, pal_idx}, 32'd0);
    chk("post2_blank", {31'd0, blank_out}, 32'd1);
    idle(3);
    send_ce(rpix());
    chk("post3_pal", {22'd0, pal_idx}, 32'h335);
    chk("post3_blank", {31'd0, blank_out}, 32'd0);
    idle(3);

    send_ce(rpix());
    idle(1);
    send_ce(rpix());
    chk("terr_set", {31'd0, timing_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(3);
      send_ce(rpix());
      chk("terr_sticky", {31'd0, timing_err}, 32'd1);
    end
    tick(1'b0, 1'b1);
    chk("terr_clr", {31'd0, timing_err}, 32'd0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      send_ce(rpix());
      idle($urandom_range(W, W + 3));
      if ($urandom_range(0, 59) == 0) begin
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
